// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: two-entry (head + skid) EX/MEM pipeline buffer with signed-overflow squashing.
//   Entries are accepted on in_valid & in_ready and presented on out_* while out_valid.
//   The head drains to MEM on out_ready.
//   flush drops every buffered entry.
//   exc_pending latches an overflow until exc_clear; while it is set, new entries are dropped.
module ex_mem_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic              out_overflow,
  output logic              exc_pending,
  input  logic              exc_clear
);
  // Only the trapping add/sub can overflow; unsigned variants and all other codes never flag.
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam int EW = 2 * DATA_W + REG_W + 5;
  localparam int M = DATA_W - 1;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [EW-1:0] head, skid, in_entry;
  logic ovf, acc, pop, load_head, load_skid, shift;
  logic unused_bits;
  // Overflow depends only on the sign bits.
  assign unused_bits = ^{alu_a[M-1:0], alu_b[M-1:0]};
  always_comb begin
    ovf = alu_control == ALU_ADD ? (alu_a[M] == alu_b[M]) && (alu_result[M] != alu_a[M]) :
          alu_control == ALU_SUB ? (alu_a[M] != alu_b[M]) && (alu_result[M] != alu_a[M]) : 1'b0;
    in_entry = {ovf, mem_to_reg, mem_write & ~ovf, mem_read & ~ovf, reg_write & ~ovf,
                rd, store_data, alu_result};
    // flush kills both handshakes; exc_pending silently swallows new entries.
    acc = in_valid & in_ready & ~exc_pending & ~flush;
    pop = out_valid & out_ready & ~flush;
    load_head = acc & (state == EMPTY | pop);
    load_skid = acc & state == ONE & ~pop;
    shift = pop & state == TWO;
    state_nx = state;
    case (state)
      EMPTY: state_nx = acc ? ONE : EMPTY;
      ONE:   state_nx = acc & ~pop ? TWO : pop & ~acc ? EMPTY : ONE;
      TWO:   state_nx = pop ? ONE : TWO;
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      head <= '0;
      skid <= '0;
      exc_pending <= 1'b0;
    end else begin
      state <= state_nx;
      in_ready <= state_nx != TWO;
      if (load_head) head <= in_entry;
      else if (shift) head <= skid;
      if (load_skid) skid <= in_entry;
      // A new overflow wins over a simultaneous acknowledge.
      if (acc & ovf) exc_pending <= 1'b1;
      else if (exc_clear) exc_pending <= 1'b0;
    end
  end
  assign out_valid = state != EMPTY;
  assign {out_overflow, out_mem_to_reg, out_mem_write, out_mem_read, out_reg_write,
          out_rd, out_store_data, out_alu_result} = head;
endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb_ex_mem_buffer: scoreboard bench for ex_mem_buffer with directed and random traffic.
module tb_ex_mem_buffer;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADDU = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SUBU = 4'b0111;
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0] rd;
    logic rw, mr, mw, mtr, ov;
  } ent_t;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] alu_a = '0, alu_b = '0, alu_result = '0, store_data = '0;
  logic [3:0] alu_control = '0;
  logic [4:0] rd = '0;
  logic reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
  logic [31:0] out_alu_result, out_store_data;
  logic [4:0] out_rd;
  logic out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_overflow, exc_pending;
  logic exc_clear = 1'b0;
  ent_t sq[$];
  logic m_exc = 1'b0;
  int nv = 0, nerr = 0;
  ex_mem_buffer dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_overflow(out_overflow), .exc_pending(exc_pending),
    .exc_clear(exc_clear)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
    nv++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Reference: a trapping op overflows when the true signed value does not fit in 32 bits.
  function automatic ent_t mk(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic [31:0] sd, input logic [4:0] r,
                              input logic rw, input logic mr, input logic mw, input logic mtr);
    longint s;
    ent_t e;
    s = ctl == ALU_SUB ? longint'($signed(a)) - longint'($signed(b))
                       : longint'($signed(a)) + longint'($signed(b));
    e.ov = (ctl == ALU_ADD || ctl == ALU_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
    e.res = res;
    e.sd = sd;
    e.rd = r;
    e.rw = rw & ~e.ov;
    e.mr = mr & ~e.ov;
    e.mw = mw & ~e.ov;
    e.mtr = mtr;
    return e;
  endfunction
  // Called at posedge+2; applies one cycle of stimulus and advances the model at the next edge.
  task automatic drive(input logic iv, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [31:0] sd, input logic [4:0] r,
                       input logic rw, input logic mr, input logic mw, input logic mtr,
                       input logic ordy, input logic fl, input logic clr);
    logic acc;
    ent_t e;
    in_valid = iv; alu_control = ctl; alu_a = a; alu_b = b; alu_result = res; store_data = sd;
    rd = r; reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = mtr;
    out_ready = ordy; flush = fl; exc_clear = clr;
    e = mk(ctl, a, b, res, sd, r, rw, mr, mw, mtr);
    acc = iv && sq.size() < 2 && !m_exc && !fl;
    @(posedge clk);
    if (fl) sq.delete();
    else if (acc) sq.push_back(e);
    if (acc && e.ov) m_exc = 1'b1;
    else if (clr) m_exc = 1'b0;
    #2;
  endtask
  task automatic idle(input logic ordy, input logic clr);
    drive(1'b0, ALU_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, 1'b0, clr);
  endtask
  task automatic put(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [4:0] r, input logic ordy);
    drive(1'b1, ctl, a, b, res, ~res, r, 1'b1, 1'b0, 1'b1, 1'b0, ordy, 1'b0, 1'b0);
  endtask
  // Monitor: mid-cycle, compare handshake and head against the scoreboard, pop on a transfer.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("in_ready", 74'(in_ready), 74'(sq.size() < 2));
      chk("out_valid", 74'(out_valid), 74'(sq.size() != 0));
      chk("exc_pending", 74'(exc_pending), 74'(m_exc));
      if (out_valid && sq.size() != 0)
        chk("head", {out_alu_result, out_store_data, out_rd, out_reg_write, out_mem_read,
                     out_mem_write, out_mem_to_reg, out_overflow}, sq[0]);
      if (out_valid && out_ready && !flush && sq.size() != 0) void'(sq.pop_front());
    end
  end
  initial begin
    logic [3:0] ops [6];
    logic [31:0] a, b, res;
    logic [3:0] ctl;
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU};
    #1 reset = 1'b1;
    #2;
    chk("rst out_valid", 74'(out_valid), 74'(0));
    chk("rst in_ready", 74'(in_ready), 74'(1));
    chk("rst exc", 74'(exc_pending), 74'(0));
    chk("rst fields", {out_alu_result, out_store_data, out_rd, out_reg_write, out_mem_read,
                       out_mem_write, out_mem_to_reg, out_overflow}, 74'(0));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    // Basic add, one-cycle latency.
    drive(1'b1, ALU_ADD, 1, 2, 3, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    // Back-to-back with a stalled consumer; third is held upstream until accepted.
    put(ALU_AND, 0, 0, 32'h11, 1, 1'b0);
    put(ALU_AND, 0, 0, 32'h22, 2, 1'b0);
    put(ALU_AND, 0, 0, 32'h33, 3, 1'b0);
    put(ALU_AND, 0, 0, 32'h33, 3, 1'b1);
    put(ALU_AND, 0, 0, 32'h33, 3, 1'b1);
    repeat (3) idle(1'b1, 1'b0);
    // Signed add overflow, then its unsigned twin after clearing.
    drive(1'b1, ALU_ADD, 32'h7FFFFFFF, 1, 32'h80000000, 0, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    drive(1'b1, ALU_ADDU, 32'h7FFFFFFF, 1, 32'h80000000, 0, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    // Subtract overflow squashes a store; following inputs dropped until the clear pulse.
    drive(1'b1, ALU_SUB, 32'h80000000, 1, 32'h7FFFFFFF, 32'hABCD, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    put(ALU_AND, 0, 0, 32'h44, 4, 1'b1);
    put(ALU_AND, 0, 0, 32'h55, 5, 1'b1);
    drive(1'b1, ALU_AND, 0, 0, 32'h66, 0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    put(ALU_AND, 0, 0, 32'h77, 7, 1'b1);
    idle(1'b1, 1'b0);
    // Flush in TWO overrides accept and pop.
    put(ALU_OR, 0, 0, 32'h88, 8, 1'b0);
    put(ALU_OR, 0, 0, 32'h99, 9, 1'b0);
    drive(1'b1, ALU_OR, 0, 0, 32'hAA, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    // Asynchronous reset mid-cycle in TWO with an exception pending.
    put(ALU_OR, 0, 0, 32'hBB, 11, 1'b0);
    drive(1'b1, ALU_ADD, 32'h80000000, 32'h80000000, 0, 0, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("arst out_valid", 74'(out_valid), 74'(0));
    chk("arst in_ready", 74'(in_ready), 74'(1));
    chk("arst exc", 74'(exc_pending), 74'(0));
    chk("arst fields", {out_alu_result, out_store_data, out_rd, out_reg_write, out_mem_read,
                        out_mem_write, out_mem_to_reg, out_overflow}, 74'(0));
    sq.delete();
    m_exc = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    // Random traffic.
    repeat (3000) begin
      ctl = ops[$urandom_range(0, 5)];
      a = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000) : $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'(int'($urandom_range(0, 2)) - 1) : $urandom;
      res = (ctl == ALU_ADD || ctl == ALU_ADDU) ? a + b : (ctl == ALU_SUB || ctl == ALU_SUBU) ? a - b : $urandom;
      drive($urandom_range(0, 3) != 0, ctl, a, b, res, $urandom, 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
    end
    repeat (4) idle(1'b1, 1'b1);
    chk("drained", 74'(sq.size()), 74'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, setting the ALU operand, result and store-data width.
REQ-002 The block SHALL have parameter REG_W, default 5, setting the destination-register index width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  discard all buffered entries (branch/jump redirect).
REQ-006 in_valid  input  1  EX stage presents an instruction.
REQ-007 in_ready  output  1  buffer accepts the presented instruction this cycle.
REQ-008 alu_a, alu_b  input  DATA_W  ALU operands, used only for overflow detection.
REQ-009 alu_control  input  4  ALU operation code (mips_pkg.vh encodings).
REQ-010 alu_result  input  DATA_W  ALU result.
REQ-011 store_data  input  DATA_W  rt value for stores.
REQ-012 rd  input  REG_W  destination register.
REQ-013 reg_write, mem_read, mem_write, mem_to_reg  input  1 each  control bits.
REQ-014 out_valid  output  1  head entry valid for MEM.
REQ-015 out_ready  input  1  MEM consumes the head entry this cycle.
REQ-016 out_alu_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  output  matching widths  head-entry fields.
REQ-017 out_overflow  output  1  head entry raised signed overflow.
REQ-018 exc_pending  output  1  sticky overflow exception flag.
REQ-019 exc_clear  input  1  exception handler acknowledges; clears exc_pending.

Function
REQ-020 The block SHALL be a two-entry buffer (head + skid) with states EMPTY, ONE, TWO.
REQ-021 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-022 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO.
REQ-023 Transitions: EMPTY+accept->ONE; ONE+accept&!pop->TWO; ONE+pop&!accept->EMPTY; ONE+accept&pop->ONE (new entry becomes head); TWO+pop->ONE (skid moves to head); otherwise hold.
REQ-024 out_valid SHALL be 1 in ONE and TWO; out_* fields SHALL always reflect the head entry and hold stable while out_valid & !out_ready.
REQ-025 Latency: an instruction accepted in EMPTY SHALL appear on out_* on the following cycle.
REQ-026 Overflow SHALL be computed at accept: ALU_ADD -> sign(a)==sign(b) and sign(result)!=sign(a); ALU_SUB -> sign(a)!=sign(b) and sign(result)!=sign(a); all other codes (including ALU_ADDU, ALU_SUBU) -> 0.
REQ-027 An overflowing entry SHALL be stored with overflow=1 and reg_write, mem_read, mem_write forced to 0; result, store_data, rd stored unchanged.
REQ-028 exc_pending SHALL set on the cycle after accepting an overflowing entry and stay set until exc_clear; a set in the same cycle as exc_clear SHALL win.
REQ-029 While exc_pending=1, accepted entries SHALL be discarded (in_ready follows REQ-022, state unchanged by them); buffered entries still drain.
REQ-030 flush SHALL force state EMPTY next cycle and override any accept or pop that cycle; exc_pending unaffected.
REQ-031 Arithmetic SHALL use DATA_W-bit operands only; no result modification besides control squashing.

Reset
REQ-032 On reset assertion, immediately: state EMPTY, out_valid=0, in_ready=1, exc_pending=0, out_overflow=0, all out_* control bits 0, all out_* data fields 0.
REQ-033 Reset SHALL override flush, accept and pop; an entry mid-transfer SHALL be lost.

Verification
REQ-034 Reset, then in_valid=1, alu_control=ALU_ADD, a=1, b=2, result=3, rd=5, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_alu_result=3, out_rd=5, out_reg_write=1, out_overflow=0.
REQ-035 out_ready=0, three back-to-back valid inputs -> first two accepted, in_ready=0 after second, third held upstream; out_ready=1 -> entries emerge in order, no loss or duplication.
REQ-036 ALU_ADD a=0x7FFFFFFF, b=1, result=0x80000000, reg_write=1 -> out_overflow=1, out_reg_write=0, exc_pending=1; same operands with ALU_ADDU -> no overflow.
REQ-037 ALU_SUB a=0x80000000, b=1, result=0x7FFFFFFF, mem_write=1 -> out_overflow=1, out_mem_write=0; following inputs dropped until exc_clear pulse, then accepted normally.
REQ-038 State TWO, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, nothing accepted.
REQ-039 Assert reset asynchronously mid-cycle in TWO with exc_pending=1 -> outputs per REQ-032 without waiting for a clock edge.
